// File: rtl/vga_rtc_frame_sync.sv
// ---------------------------------------------------------------------------
// vga_rtc_frame_sync
//
// Moves RTC time/date/timer fields into the VGA text renderer once per frame,
// aligned to vertical blanking so a half-updated value is never displayed.
// A falling edge of VS (frame start) requests one snapshot from the RTC read
// engine. The acknowledged data is held in a shadow register and committed to
// the renderer on the following rising edge of VS, which is still inside
// blanking. The module also generates the frame-locked alarm blink gate.
//
// Optional feature (macro VGA_RTC_BCD_CHECK_EN):
//   When defined, every nibble of acknowledged RTC data must be <= 9. Bad
//   data is dropped, the request is closed and o_bcd_err pulses for one cycle.
//   When undefined, data is accepted as-is and o_bcd_err does not exist.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_vs           vertical sync, active-low pulse
//   i_alarma       alarm active level from RTC control
//   i_rtc_ack      one-cycle pulse, i_rtc_data valid in that cycle
//   i_rtc_data     {DIA,MES,ANO,HORA,MINUTO,SEGUNDO,HORAT,MINUTOT,SEGUNDOT},
//                  8-bit BCD each, DIA in the MSBs
//   o_rtc_req      snapshot request to the RTC read engine
//   o_disp_data    committed fields to the renderer, same packing
//   o_update_done  one-cycle pulse on commit
//   o_alarm_blink  blink gate for the alarm indicator
//   o_timeout_err  sticky request-timeout flag, cleared by the next commit
//   o_bcd_err      (VGA_RTC_BCD_CHECK_EN only) one-cycle pulse on bad data
// ---------------------------------------------------------------------------
module vga_rtc_frame_sync #(
  parameter int BLINK_FRAMES = 30,   // frames per blink half-period, 1..255
  parameter int REQ_TIMEOUT  = 4095  // cycles allowed in REQ, 1..65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vs,
  input  logic        i_alarma,
  input  logic        i_rtc_ack,
  input  logic [71:0] i_rtc_data,
  output logic        o_rtc_req,
  output logic [71:0] o_disp_data,
  output logic        o_update_done,
  output logic        o_alarm_blink,
  output logic        o_timeout_err
`ifdef VGA_RTC_BCD_CHECK_EN
  ,
  output logic        o_bcd_err
`endif
);

  // Terminal values of the counters; the request expires on the cycle the
  // timeout counter would reach REQ_TIMEOUT, so RTC_REQ is high for exactly
  // REQ_TIMEOUT cycles.
  localparam logic [15:0] LP_TO_LAST    = 16'(REQ_TIMEOUT - 1);
  localparam logic [7:0]  LP_BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ         = 2'd1,
    ST_WAIT_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vs_d;
  logic [71:0] r_shadow;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_blink_cnt;
  logic        r_rtc_req;
  logic [71:0] r_disp_data;
  logic        r_update_done;
  logic        r_alarm_blink;
  logic        r_timeout_err;
  logic        r_bcd_err;

  logic        w_fall;
  logic        w_rise;
  logic        w_data_ok;
  logic        w_load_shadow;
  logic        w_commit;
  logic        w_expire;
  logic        w_bcd_bad;
  logic        w_cnt_clr;
  logic        w_cnt_inc;

`ifdef VGA_RTC_BCD_CHECK_EN
  // True when all 18 nibbles hold a decimal digit.
  function automatic logic f_all_bcd(input logic [71:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (d[i*4 +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  assign w_data_ok = f_all_bcd(i_rtc_data);
  assign o_bcd_err = r_bcd_err;
`else
  assign w_data_ok = 1'b1;
`endif

  // Edges of the registered sync: fall starts a frame, rise ends the sync
  // pulse while the display is still blanked.
  assign w_fall = r_vs_d & ~i_vs;
  assign w_rise = ~r_vs_d & i_vs;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_shadow = 1'b0;
    w_commit      = 1'b0;
    w_expire      = 1'b0;
    w_bcd_bad     = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_REQ;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        // ACK has priority over an expiry in the same cycle; further falls
        // are ignored here, so the counter keeps running.
        if (i_rtc_ack) begin
          if (w_data_ok) begin
            w_load_shadow = 1'b1;
            w_state_nxt   = ST_WAIT_COMMIT;
          end else begin
            w_bcd_bad   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT_COMMIT: begin
        // A rise seen in the same cycle as the ACK was consumed in REQ, so a
        // late ACK is committed on the next frame's rise.
        if (w_rise) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_COMMIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sync delay, request/timeout handling, shadow and committed display data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_d        <= 1'b1;
      r_rtc_req     <= 1'b0;
      r_to_cnt      <= 16'd0;
      r_shadow      <= 72'd0;
      r_disp_data   <= 72'd0;
      r_update_done <= 1'b0;
      r_timeout_err <= 1'b0;
      r_bcd_err     <= 1'b0;
    end else begin
      r_vs_d        <= i_vs;
      r_rtc_req     <= (w_state_nxt == ST_REQ);
      r_update_done <= w_commit;
      r_bcd_err     <= w_bcd_bad;

      if (w_cnt_clr) begin
        r_to_cnt <= 16'd0;
      end else if (w_cnt_inc) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end else begin
        r_to_cnt <= r_to_cnt;
      end

      if (w_load_shadow) begin
        r_shadow <= i_rtc_data;
      end else begin
        r_shadow <= r_shadow;
      end

      if (w_commit) begin
        r_disp_data <= r_shadow;
      end else begin
        r_disp_data <= r_disp_data;
      end

      if (w_commit) begin
        r_timeout_err <= 1'b0;
      end else if (w_expire) begin
        r_timeout_err <= 1'b1;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
    end
  end

  // Alarm blink: advanced once per frame on the VS rise only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink_cnt   <= 8'd0;
      r_alarm_blink <= 1'b0;
    end else if (w_rise) begin
      if (!i_alarma) begin
        r_blink_cnt   <= 8'd0;
        r_alarm_blink <= 1'b0;
      end else if (r_blink_cnt == LP_BLINK_LAST) begin
        r_blink_cnt   <= 8'd0;
        r_alarm_blink <= ~r_alarm_blink;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 8'd1;
        r_alarm_blink <= r_alarm_blink;
      end
    end else begin
      r_blink_cnt   <= r_blink_cnt;
      r_alarm_blink <= r_alarm_blink;
    end
  end

  assign o_rtc_req     = r_rtc_req;
  assign o_disp_data   = r_disp_data;
  assign o_update_done = r_update_done;
  assign o_alarm_blink = r_alarm_blink;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vga_rtc_frame_sync.sv
module tb_vga_rtc_frame_sync;

  logic        clk;
  logic        rst;
  logic        vs;
  logic        alarma;
  logic        rtc_ack;
  logic [71:0] rtc_data;
  logic        rtc_req;
  logic [71:0] disp_data;
  logic        update_done;
  logic        alarm_blink;
  logic        timeout_err;
`ifdef VGA_RTC_BCD_CHECK_EN
  logic        bcd_err;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_upd    = 0;
  logic [71:0] exp_q[$];
  logic [71:0] exp_v;

  localparam logic [71:0] D1   = 72'h12_34_56_78_90_00_00_00_00;
  localparam logic [71:0] D2   = 72'h31_12_24_23_59_58_01_02_03;
  localparam logic [71:0] D3   = 72'h01_01_25_00_00_01_00_00_10;
  localparam logic [71:0] D4   = 72'h15_06_26_12_30_45_00_05_00;
  localparam logic [71:0] D5   = 72'h28_02_27_07_07_07_00_00_59;
  localparam logic [71:0] D6   = 72'h09_09_29_19_19_19_01_01_01;
  localparam logic [71:0] JUNK = 72'h99_99_99_99_99_99_99_99_99;

  vga_rtc_frame_sync #(
    .BLINK_FRAMES(2),
    .REQ_TIMEOUT (100)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_vs         (vs),
    .i_alarma     (alarma),
    .i_rtc_ack    (rtc_ack),
    .i_rtc_data   (rtc_data),
    .o_rtc_req    (rtc_req),
    .o_disp_data  (disp_data),
    .o_update_done(update_done),
    .o_alarm_blink(alarm_blink),
    .o_timeout_err(timeout_err)
`ifdef VGA_RTC_BCD_CHECK_EN
    ,
    .o_bcd_err    (bcd_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count commit pulses seen anywhere in the run
  always @(negedge clk) begin
    if (update_done === 1'b1) n_upd = n_upd + 1;
  end

  // one clock edge, then settle; inputs are driven and outputs sampled here
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack(input logic [71:0] d, input logic expect_commit);
    rtc_ack  = 1'b1;
    rtc_data = d;
    if (expect_commit) exp_q.push_back(d);
    tick(1);
    rtc_ack  = 1'b0;
    rtc_data = 72'd0;
  endtask

  task automatic test_reset;
    int req_cnt;
    rst = 1'b1; vs = 1'b1; alarma = 1'b0; rtc_ack = 1'b0; rtc_data = 72'd0;
    tick(10);
    rst = 1'b0;
    n_checks++;
    if (rtc_req !== 1'b0 || update_done !== 1'b0 || alarm_blink !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL reset_ctrl: req=%b upd=%b blink=%b to=%b, required all 0", rtc_req, update_done, alarm_blink, timeout_err);
    else n_pass++;
    n_checks++;
    if (disp_data !== 72'd0) $display("FAIL reset_disp: got %h required 0", disp_data);
    else n_pass++;
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rtc_req === 1'b1) req_cnt++;
    end
    n_checks++;
    if (req_cnt !== 0) $display("FAIL reset_req_idle: req high %0d cycles, required 0", req_cnt);
    else n_pass++;
  endtask

  task automatic test_commit;
    int req_cnt;
    int upd0;
    req_cnt = 0;
    upd0 = n_upd;
    vs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rtc_req === 1'b1) req_cnt++;
    end
    pulse_ack(D1, 1'b1);
    for (int i = 21; i < 1600; i++) begin
      if (rtc_req === 1'b1) req_cnt++;
      tick(1);
    end
    n_checks++;
    if (req_cnt !== 20) $display("FAIL commit_req_len: req high %0d cycles, required 20", req_cnt);
    else n_pass++;
    n_checks++;
    if (n_upd !== upd0) $display("FAIL commit_early: %0d commits before rise, required 0", n_upd - upd0);
    else n_pass++;
    vs = 1'b1;
    tick(1);
    n_checks++;
    if (update_done !== 1'b1) $display("FAIL commit_pulse: upd=%b required 1", update_done);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL commit_data: no expected value queued, got %h", disp_data);
    else begin
      exp_v = exp_q.pop_front();
      if (disp_data !== exp_v) $display("FAIL commit_data: got %h required %h", disp_data, exp_v);
      else n_pass++;
    end
    tick(1);
    n_checks++;
    if (update_done !== 1'b0) $display("FAIL commit_pulse_width: upd=%b required 0", update_done);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int req_cnt;
    req_cnt = 0;
    tick(5);
    vs = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (rtc_req === 1'b1) req_cnt++;
    end
    n_checks++;
    if (req_cnt !== 100) $display("FAIL timeout_req_len: req high %0d cycles, required 100", req_cnt);
    else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b1 || disp_data !== D1)
      $display("FAIL timeout_flag: to=%b disp=%h, required 1 and %h", timeout_err, disp_data, D1);
    else n_pass++;
    vs = 1'b1;
    tick(5);
    vs = 1'b0;
    tick(5);
    pulse_ack(D2, 1'b1);
    tick(20);
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: to=%b required 1", timeout_err);
    else n_pass++;
    vs = 1'b1;
    tick(1);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL timeout_recover: no expected value queued");
    else begin
      exp_v = exp_q.pop_front();
      if (update_done !== 1'b1 || disp_data !== exp_v || timeout_err !== 1'b0)
        $display("FAIL timeout_recover: upd=%b disp=%h to=%b, required 1 %h 0", update_done, disp_data, timeout_err, exp_v);
      else n_pass++;
    end
    tick(5);
  endtask

  task automatic test_late_ack;
    int req_cnt;
    int upd0;
    upd0 = n_upd;
    vs = 1'b0;
    tick(30);
    vs = 1'b1;
    tick(50);
    pulse_ack(D3, 1'b1);
    tick(20);
    n_checks++;
    if (n_upd !== upd0) $display("FAIL late_no_commit: %0d commits, required 0", n_upd - upd0);
    else n_pass++;
    req_cnt = 0;
    vs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rtc_req === 1'b1) req_cnt++;
    end
    n_checks++;
    if (req_cnt !== 0) $display("FAIL late_no_rereq: req high %0d cycles, required 0", req_cnt);
    else n_pass++;
    vs = 1'b1;
    tick(1);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL late_commit: no expected value queued");
    else begin
      exp_v = exp_q.pop_front();
      if (update_done !== 1'b1 || disp_data !== exp_v)
        $display("FAIL late_commit: upd=%b disp=%h, required 1 %h", update_done, disp_data, exp_v);
      else n_pass++;
    end
    tick(5);
  endtask

  task automatic test_back_to_back;
    tick(3);
    pulse_ack(JUNK, 1'b0);  // not in REQ: must be ignored
    n_checks++;
    if (rtc_req !== 1'b0) $display("FAIL idle_ack_req: req=%b required 0", rtc_req);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      vs = 1'b0;
      tick(5);
      pulse_ack((f == 0) ? D4 : D5, 1'b1);
      tick(10);
      vs = 1'b1;
      tick(1);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL b2b_commit%0d: no expected value queued", f);
      else begin
        exp_v = exp_q.pop_front();
        if (update_done !== 1'b1 || disp_data !== exp_v)
          $display("FAIL b2b_commit%0d: upd=%b disp=%h, required 1 %h", f, update_done, disp_data, exp_v);
        else n_pass++;
      end
      tick(10);
    end
  endtask

  task automatic test_blink;
    int   bcnt;
    logic bexp;
    int   toggles;
    logic prev;
    bcnt = 0; bexp = 1'b0; toggles = 0;
    prev = alarm_blink;
    alarma = 1'b1;
    for (int f = 0; f < 8; f++) begin
      vs = 1'b0;
      tick(3);
      vs = 1'b1;
      tick(1);
      if (bcnt == 1) begin bcnt = 0; bexp = ~bexp; end
      else bcnt++;
      if (alarm_blink !== prev) toggles++;
      prev = alarm_blink;
      n_checks++;
      if (alarm_blink !== bexp) $display("FAIL blink_frame%0d: blink=%b required %b", f, alarm_blink, bexp);
      else n_pass++;
      tick(3);
    end
    n_checks++;
    if (toggles !== 4) $display("FAIL blink_toggles: %0d toggles, required 4", toggles);
    else n_pass++;
    // mid-frame change takes effect only at the rise
    vs = 1'b0;
    tick(2);
    alarma = 1'b0;
    tick(2);
    n_checks++;
    if (alarm_blink !== bexp) $display("FAIL blink_midframe: blink=%b required %b", alarm_blink, bexp);
    else n_pass++;
    vs = 1'b1;
    tick(1);
    n_checks++;
    if (alarm_blink !== 1'b0) $display("FAIL blink_off: blink=%b required 0", alarm_blink);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    tick(120);
    vs = 1'b0;
    tick(3);
    n_checks++;
    if (rtc_req !== 1'b1) $display("FAIL rstmid_req_before: req=%b required 1", rtc_req);
    else n_pass++;
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (rtc_req !== 1'b0 || disp_data !== 72'd0 || timeout_err !== 1'b0 || update_done !== 1'b0)
      $display("FAIL rstmid_state: req=%b disp=%h to=%b upd=%b, required all 0", rtc_req, disp_data, timeout_err, update_done);
    else n_pass++;
    vs = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    n_checks++;
    if (rtc_req !== 1'b0) $display("FAIL rstmid_after: req=%b required 0", rtc_req);
    else n_pass++;
  endtask

`ifdef VGA_RTC_BCD_CHECK_EN
  task automatic test_bcd;
    int upd0;
    vs = 1'b0;
    tick(5);
    pulse_ack(D6, 1'b1);
    tick(10);
    vs = 1'b1;
    tick(1);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL bcd_good: no expected value queued");
    else begin
      exp_v = exp_q.pop_front();
      if (disp_data !== exp_v) $display("FAIL bcd_good: disp=%h required %h", disp_data, exp_v);
      else n_pass++;
    end
    tick(10);
    upd0 = n_upd;
    vs = 1'b0;
    tick(5);
    pulse_ack(72'h1A_01_25_00_00_00_00_00_00, 1'b0);
    n_checks++;
    if (bcd_err !== 1'b1 || rtc_req !== 1'b0) $display("FAIL bcd_err_pulse: err=%b req=%b, required 1 0", bcd_err, rtc_req);
    else n_pass++;
    tick(1);
    n_checks++;
    if (bcd_err !== 1'b0) $display("FAIL bcd_err_width: err=%b required 0", bcd_err);
    else n_pass++;
    tick(10);
    vs = 1'b1;
    tick(3);
    n_checks++;
    if (n_upd !== upd0 || disp_data !== D6) $display("FAIL bcd_no_commit: commits=%0d disp=%h, required 0 %h", n_upd - upd0, disp_data, D6);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_commit;
    test_timeout;
    test_late_ack;
    test_back_to_back;
    test_blink;
    test_reset_mid;
`ifdef VGA_RTC_BCD_CHECK_EN
    test_bcd;
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
